// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for memory_arbiter: FSM state encoding and one-hot/index conversion.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Helpers are sized for the largest supported requester count.
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_REQ_W = 3;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_REQ_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

  function automatic logic [MAX_REQ_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_REQ_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_REQ_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Round-robin picker: rotate requests by the pointer, take the lowest set bit, rotate back.
module rr_picker #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_rot_gnt;
  logic [2*N-1:0] w_unrot;

  always_comb begin
    w_dbl = {i_req, i_req} >> i_ptr;
    w_rot = w_dbl[N-1:0];
    w_rot_gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_rot_gnt    = '0;
        w_rot_gnt[i] = 1'b1;
      end
    end
    w_unrot = {w_rot_gnt, w_rot_gnt} << i_ptr;
    o_gnt   = w_unrot[2*N-1:N];
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates N_REQ requesters onto one sync-read RAM with burst locking.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index).
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BIT_SIZE = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ-1:0]          i_req_we,
  input  logic [N_REQ-1:0]          i_req_lock,
  input  logic [N_REQ*DEPTH-1:0]    i_req_addr,
  input  logic [N_REQ*BIT_SIZE-1:0] i_req_wdata,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [BIT_SIZE-1:0]       o_rsp_data,
  output logic                      o_mem_we,
  output logic [DEPTH-1:0]          o_mem_raddr,
  output logic [DEPTH-1:0]          o_mem_waddr,
  output logic [BIT_SIZE-1:0]       o_mem_wdata,
  input  logic [BIT_SIZE-1:0]       i_mem_rdata
);

  localparam int unsigned REQ_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       r_state;
  logic [REQ_W-1:0] r_owner;
  logic [N_REQ-1:0] r_rsp_valid;

  logic [N_REQ-1:0] w_pick;
  logic [N_REQ-1:0] w_owner_oh;
  logic [N_REQ-1:0] w_grant;
  logic [REQ_W-1:0] w_grant_idx;
  logic             w_any;

`ifdef MEM_ARB_RR_EN
  logic [REQ_W-1:0] r_rr_ptr;

  rr_picker #(
    .N (N_REQ),
    .W (REQ_W)
  ) u_rr_picker (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick)
  );
`else
  always_comb begin
    w_pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        w_pick    = '0;
        w_pick[i] = 1'b1;
      end
    end
  end
`endif

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    w_owner_oh = N_REQ'(idx_to_onehot(MAX_REQ_W'(r_owner)));
    if (!i_rst_n)                w_grant = '0;
    else if (r_state == OWNED)   w_grant = w_owner_oh & i_req_valid;
    else                         w_grant = w_pick;
    w_grant_idx = REQ_W'(onehot_to_idx(MAX_REQ'(w_grant)));
    w_any       = |w_grant;

    o_mem_raddr = '0;
    o_mem_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        o_mem_raddr = i_req_addr[i*DEPTH +: DEPTH];
        o_mem_wdata = i_req_wdata[i*BIT_SIZE +: BIT_SIZE];
      end
    end
    o_mem_waddr = o_mem_raddr;
    o_mem_we    = |(w_grant & i_req_we);
    o_req_ready = w_grant;
    o_rsp_valid = r_rsp_valid;
    o_rsp_data  = (|r_rsp_valid) ? i_mem_rdata : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rsp_valid <= '0;
`ifdef MEM_ARB_RR_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      r_rsp_valid <= w_grant & ~i_req_we;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            if (|(w_grant & i_req_lock)) begin
              r_state <= OWNED;
              r_owner <= w_grant_idx;
            end
`ifdef MEM_ARB_RR_EN
            r_rr_ptr <= (w_grant_idx == REQ_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
`endif
          end
        end
        // Dropping lock releases the bus whether or not the owner issued a beat.
        OWNED: begin
          if (!(|(w_owner_oh & i_req_lock))) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
